// File: rtl/knn_point_streamer.sv
// knn_point_streamer
//   Transmit end of the KNN accelerator's reference/data input interface.
//   Splits a flat valid/ready word stream into one reference point, then
//   num_points query points (a name word followed by one word per
//   dimension), then a single-cycle done_out pulse.
//
// Ports
//   clk            system clock, rising edge
//   reset_sync     asynchronous, active-high reset
//   start          one-cycle job request, honoured only while idle
//   num_points     query point count, captured when start is accepted
//   s_data/s_valid incoming stream word and its valid flag
//   s_ready        streamer accepts s_data this cycle (state-only decode)
//   ref_data_out   reference coordinate, qualified by load_ref
//   data_name_out  identifier of the current query point
//   data_value_out query coordinate, qualified by data_valid
//   done_out       one-cycle pulse after the last coordinate of the job
//   busy           high whenever a job is in progress
module knn_point_streamer #(
   parameter int dataWidth          = 32,
   parameter int numberOfDimensions = 32
) (
   input  logic                 clk,
   input  logic                 reset_sync,
   input  logic                 start,
   input  logic [31:0]          num_points,
   input  logic [dataWidth-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [dataWidth-1:0] ref_data_out,
   output logic                 load_ref,
   output logic [31:0]          data_name_out,
   output logic [dataWidth-1:0] data_value_out,
   output logic                 data_valid,
   output logic                 done_out,
   output logic                 busy
);

   localparam int dimW = $clog2(numberOfDimensions + 1);
   localparam logic [dimW-1:0] lastDim = dimW'(numberOfDimensions - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REF,
      GET_NAME,
      STREAM_DIMS,
      DONE_PULSE
   } state_t;

   state_t          state;
   state_t          nextState;
   logic [dimW-1:0] dimCnt;
   logic [31:0]     ptCnt;
   logic [31:0]     numPointsQ;
   logic [31:0]     ptCntInc;
   logic [31:0]     nameWord;
   logic            xfer;
   logic            atLastDim;

   // Names are 32 bits wide regardless of the coordinate width.
   if (dataWidth >= 32) begin : gNameWide
      assign nameWord = s_data[31:0];
   end else begin : gNameNarrow
      assign nameWord = {{(32 - dataWidth){1'b0}}, s_data};
   end

   assign xfer      = s_valid && s_ready;
   assign atLastDim = (dimCnt == lastDim);
   // ptCnt is strictly below numPointsQ whenever this is used, so the
   // increment cannot wrap even for num_points = 0xFFFFFFFF.
   assign ptCntInc  = ptCnt + 32'd1;
   assign busy      = (state != IDLE);

   // NOTE: every signal driven here gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      nextState = state;
      s_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = LOAD_REF;
         end
         LOAD_REF: begin
            s_ready = 1'b1;
            if (s_valid && atLastDim)
               nextState = (numPointsQ == 32'd0) ? DONE_PULSE : GET_NAME;
         end
         GET_NAME: begin
            s_ready = 1'b1;
            if (s_valid) nextState = STREAM_DIMS;
         end
         STREAM_DIMS: begin
            s_ready = 1'b1;
            if (s_valid && atLastDim)
               nextState = (ptCntInc == numPointsQ) ? DONE_PULSE : GET_NAME;
         end
         DONE_PULSE: nextState = IDLE;
         default:    nextState = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) state <= IDLE;
      else            state <= nextState;
   end

   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         dimCnt         <= '0;
         ptCnt          <= '0;
         numPointsQ     <= '0;
         ref_data_out   <= '0;
         load_ref       <= 1'b0;
         data_name_out  <= '0;
         data_value_out <= '0;
         data_valid     <= 1'b0;
         done_out       <= 1'b0;
      end else begin
         load_ref   <= 1'b0;
         data_valid <= 1'b0;
         // Registered one cycle behind DONE_PULSE so it can never coincide
         // with the final data_valid/load_ref strobe.
         done_out   <= (state == DONE_PULSE);
         case (state)
            IDLE: begin
               if (start) begin
                  numPointsQ <= num_points;
                  dimCnt     <= '0;
                  ptCnt      <= '0;
               end
            end
            LOAD_REF: begin
               if (xfer) begin
                  ref_data_out <= s_data;
                  load_ref     <= 1'b1;
                  dimCnt       <= atLastDim ? '0 : dimCnt + dimW'(1);
               end
            end
            GET_NAME: begin
               if (xfer) data_name_out <= nameWord;
            end
            STREAM_DIMS: begin
               if (xfer) begin
                  data_value_out <= s_data;
                  data_valid     <= 1'b1;
                  if (atLastDim) begin
                     dimCnt <= '0;
                     ptCnt  <= ptCntInc;
                  end else begin
                     dimCnt <= dimCnt + dimW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_point_streamer.sv
// tb_knn_point_streamer
//   Directed bench for knn_point_streamer. One instance uses the default
//   32-dimension configuration, a second runs with a single dimension.
//   Stream word k carries the value k, so the expected reference, name and
//   coordinate sequences follow directly from the word position.
module tb_knn_point_streamer;

   localparam int DIMS = 32;

   typedef struct {
      logic [31:0] np;
      bit          gap;
      bit          midStart;
      int          expRefs;
      int          expVals;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_sync;
   logic        start;
   logic [31:0] num_points;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] ref_data_out;
   logic        load_ref;
   logic [31:0] data_name_out;
   logic [31:0] data_value_out;
   logic        data_valid;
   logic        done_out;
   logic        busy;

   logic        start1;
   logic [31:0] numPoints1;
   logic [31:0] sData1;
   logic        sValid1;
   logic        sReady1;
   logic [31:0] refData1;
   logic        loadRef1;
   logic [31:0] name1;
   logic [31:0] value1;
   logic        valid1;
   logic        done1;
   logic        busy1;

   always #5 clk = ~clk;

   knn_point_streamer dut (
      .clk(clk), .reset_sync(reset_sync), .start(start), .num_points(num_points),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .ref_data_out(ref_data_out), .load_ref(load_ref),
      .data_name_out(data_name_out), .data_value_out(data_value_out),
      .data_valid(data_valid), .done_out(done_out), .busy(busy)
   );

   knn_point_streamer #(.dataWidth(32), .numberOfDimensions(1)) dut1 (
      .clk(clk), .reset_sync(reset_sync), .start(start1), .num_points(numPoints1),
      .s_data(sData1), .s_valid(sValid1), .s_ready(sReady1),
      .ref_data_out(refData1), .load_ref(loadRef1),
      .data_name_out(name1), .data_value_out(value1),
      .data_valid(valid1), .done_out(done1), .busy(busy1)
   );

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   bit lastXfer = 1'b0;
   logic [31:0] refLog[$];
   logic [31:0] nameLog[$];
   logic [31:0] valLog[$];
   int doneCnt, orphan, overlap, lastStrobeCyc, doneCyc;
   logic busyAtDone;
   logic [31:0] ref1Log[$];
   logic [31:0] name1Log[$];
   logic [31:0] val1Log[$];
   int done1Cnt, overlap1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clearLogs();
      refLog.delete(); nameLog.delete(); valLog.delete();
      ref1Log.delete(); name1Log.delete(); val1Log.delete();
      doneCnt = 0; orphan = 0; overlap = 0; lastStrobeCyc = 0; doneCyc = -100;
      busyAtDone = 1'b1; done1Cnt = 0; overlap1 = 0;
   endtask

   // Mid-cycle observation of both instances; lastXfer says whether the
   // preceding rising edge carried a transfer into dut.
   task automatic sample();
      if ((load_ref || data_valid) && !lastXfer) orphan++;
      if (load_ref) begin refLog.push_back(ref_data_out); lastStrobeCyc = cyc; end
      if (data_valid) begin
         nameLog.push_back(data_name_out);
         valLog.push_back(data_value_out);
         lastStrobeCyc = cyc;
      end
      if (done_out) begin doneCnt++; doneCyc = cyc; busyAtDone = busy; end
      if (done_out && data_valid) overlap++;
      if (loadRef1) ref1Log.push_back(refData1);
      if (valid1) begin name1Log.push_back(name1); val1Log.push_back(value1); end
      if (done1) done1Cnt++;
      if (done1 && valid1) overlap1++;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      sample();
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      s_valid  = v;
      s_data   = d;
      lastXfer = v && s_ready;
   endtask

   task automatic runJob(input vec_t v, input int id);
      int w, c, totWords, refErr, nameErr, valErr, busyDrop, readyDrop, readyAfter;
      bit seenReady;
      logic [31:0] expName;
      clearLogs();
      start = 1'b1; num_points = v.np; drive(1'b0, 32'd0);
      tick();
      start = 1'b0;
      totWords = DIMS + int'(v.np) * (DIMS + 1);
      w = 0; c = 0; busyDrop = 0; readyDrop = 0; readyAfter = 0; seenReady = 1'b0;
      while (doneCnt == 0 && c < 400) begin
         if (v.midStart && c == 40) begin start = 1'b1; num_points = 32'd7; end
         else start = 1'b0;
         if (!busy) busyDrop++;
         if (w < totWords) begin
            if (s_ready) seenReady = 1'b1;
            else if (seenReady) readyDrop++;
         end else if (s_ready) readyAfter++;
         drive((w < totWords) && (!v.gap || (c % 2 == 0)), w);
         if (lastXfer) w++;
         tick();
         c++;
      end
      start = 1'b0; drive(1'b0, 32'd0);
      repeat (4) tick();

      refErr = 0; nameErr = 0; valErr = 0;
      foreach (refLog[i]) if (refLog[i] !== 32'(i)) refErr++;
      foreach (valLog[i]) begin
         expName = 32'(DIMS + (i / DIMS) * (DIMS + 1));
         if (nameLog[i] !== expName) nameErr++;
         if (valLog[i] !== expName + 32'd1 + 32'(i % DIMS)) valErr++;
      end
      check($sformatf("job%0d ref_count", id), refLog.size(), v.expRefs);
      check($sformatf("job%0d ref_values", id), refErr, 0);
      check($sformatf("job%0d val_count", id), valLog.size(), v.expVals);
      check($sformatf("job%0d names", id), nameErr, 0);
      check($sformatf("job%0d values", id), valErr, 0);
      check($sformatf("job%0d done_count", id), doneCnt, 1);
      check($sformatf("job%0d done_gap", id), doneCyc - lastStrobeCyc, 1);
      check($sformatf("job%0d done_overlap", id), overlap, 0);
      check($sformatf("job%0d busy_at_done", id), busyAtDone, 1'b0);
      check($sformatf("job%0d busy_drop", id), busyDrop, 0);
      check($sformatf("job%0d ready_drop", id), readyDrop, 0);
      check($sformatf("job%0d ready_after_last", id), readyAfter, 0);
      check($sformatf("job%0d orphan_strobes", id), orphan, 0);
   endtask

   initial begin
      vec_t vecs[4];
      vec_t recoverVec;
      logic [31:0] words1[7];
      int w, c, idx;

      reset_sync = 1'b1; start = 1'b0; num_points = '0; s_data = '0; s_valid = 1'b0;
      start1 = 1'b0; numPoints1 = '0; sData1 = '0; sValid1 = 1'b0;
      clearLogs();
      #1;
      check("reset_ctrl", {s_ready, load_ref, data_valid, done_out, busy}, '0);
      check("reset_data", ref_data_out | data_name_out | data_value_out, '0);
      check("reset_ctrl_d1", {sReady1, loadRef1, valid1, done1, busy1}, '0);
      repeat (2) tick();
      reset_sync = 1'b0;

      // np, gap, midStart, expected reference strobes, expected data strobes
      vecs[0] = '{32'd2, 1'b0, 1'b0, 32, 64};
      vecs[1] = '{32'd2, 1'b1, 1'b0, 32, 64};
      vecs[2] = '{32'd0, 1'b0, 1'b0, 32, 0};
      vecs[3] = '{32'd2, 1'b0, 1'b1, 32, 64};
      for (int i = 0; i < 4; i++) runJob(vecs[i], i);

      // Reset in the middle of the first query point.
      clearLogs();
      start = 1'b1; num_points = 32'd2; drive(1'b0, 32'd0);
      tick();
      start = 1'b0; w = 0; c = 0;
      while (w < DIMS + 1 + 10 && c < 200) begin
         drive(1'b1, w);
         if (lastXfer) w++;
         tick();
         c++;
      end
      check("mid_reset_pre_strobe", data_valid, 1'b1);
      drive(1'b0, 32'd0);
      #1 reset_sync = 1'b1;
      #1;
      check("mid_reset_ctrl", {s_ready, load_ref, data_valid, done_out, busy}, '0);
      check("mid_reset_data", ref_data_out | data_name_out | data_value_out, '0);
      repeat (3) tick();
      reset_sync = 1'b0;
      repeat (3) tick();
      check("mid_reset_no_done", doneCnt, 0);
      check("mid_reset_idle", {s_ready, busy}, 2'b00);
      recoverVec = '{32'd1, 1'b0, 1'b0, 32, 32};
      runJob(recoverVec, 4);

      // Single-dimension instance: A, N0, V0, N1, V1, N2, V2.
      clearLogs();
      words1 = '{32'hA, 32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
      start1 = 1'b1; numPoints1 = 32'd3;
      tick();
      start1 = 1'b0; idx = 0; c = 0;
      while (done1Cnt == 0 && c < 50) begin
         sValid1 = (idx < 7);
         sData1  = (idx < 7) ? words1[idx] : 32'd0;
         if (sValid1 && sReady1) idx++;
         tick();
         c++;
      end
      sValid1 = 1'b0;
      repeat (3) tick();
      check("d1_ref_count", ref1Log.size(), 1);
      if (ref1Log.size() > 0) check("d1_ref_value", ref1Log[0], 32'hA);
      check("d1_val_count", val1Log.size(), 3);
      for (int i = 0; i < 3 && i < val1Log.size(); i++) begin
         check($sformatf("d1_name%0d", i), name1Log[i], 32'h100 + 32'(i));
         check($sformatf("d1_value%0d", i), val1Log[i], 32'h200 + 32'(i));
      end
      check("d1_done_count", done1Cnt, 1);
      check("d1_done_overlap", overlap1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
